color_obj_detect: RTL and testbench

- Sits directly downstream of the OV7670 capture stage: consumes its pixel-write stream (addr, 12-bit RGB444 data, we) and forwards it, delayed, to the frame buffer.
- Classifies each pixel against a programmable colour threshold and accumulates, per frame, the bounding box and count of matching pixels.
- Optionally paints matched pixels and the previous frame's bounding box into the forwarded stream for VGA display.

---
 rtl/color_obj_detect_pkg.sv | 65 ++++++
 rtl/color_obj_detect_if.sv | 35 +++
 rtl/color_obj_detect_track.sv | 101 ++++++++++
 rtl/color_obj_detect.sv | 169 ++++++++++++++++
 tb/tb_color_obj_detect.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_obj_detect_pkg.sv
// Shared image geometry, colour encodings and helpers for the colour-object detector.
package color_obj_detect_pkg;

  localparam int unsigned c_img_cols     = 80;
  localparam int unsigned c_img_rows     = 60;
  localparam int unsigned c_img_pxls     = c_img_cols * c_img_rows;
  localparam int unsigned c_nb_line_pxls = 7;
  localparam int unsigned c_nb_rows      = 6;
  localparam int unsigned c_nb_img_pxls  = 13;
  localparam int unsigned c_nb_buf       = 12;
  localparam int unsigned c_nb_chan      = 4;

  localparam logic [c_nb_buf-1:0] c_match_color = 12'hFFF;
  localparam logic [c_nb_buf-1:0] c_box_color   = 12'hF0F;

  localparam logic [c_nb_img_pxls-1:0] c_pxls_addr = c_nb_img_pxls'(c_img_pxls);
  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_img_pxls-1:0] c_cols_addr = c_nb_img_pxls'(c_img_cols);

  typedef enum logic [1:0] {
    C_SEL_RED   = 2'd0,
    C_SEL_GREEN = 2'd1,
    C_SEL_BLUE  = 2'd2,
    C_SEL_OFF   = 2'd3
  } color_sel_e;

  typedef enum logic {
    TRK_IDLE   = 1'b0,
    TRK_ACTIVE = 1'b1
  } trk_state_e;

  // Bounding box plus matched-pixel count for one frame
  typedef struct packed {
    logic [c_nb_line_pxls-1:0] xmin;
    logic [c_nb_line_pxls-1:0] xmax;
    logic [c_nb_rows-1:0]      ymin;
    logic [c_nb_rows-1:0]      ymax;
    logic [c_nb_img_pxls-1:0]  cnt;
  } bbox_t;

  // Empty working box: min at all-ones, max at zero, so the first match sets both
  localparam bbox_t c_bbox_init = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, cnt: '0};

  // Selected channel at or above thr_main, the other two at or below thr_other
  function automatic logic pix_match(input logic [c_nb_buf-1:0]  px,
                                     input color_sel_e           sel,
                                     input logic [c_nb_chan-1:0] thr_main,
                                     input logic [c_nb_chan-1:0] thr_other);
    logic [c_nb_chan-1:0] r;
    logic [c_nb_chan-1:0] g;
    logic [c_nb_chan-1:0] b;
    logic                 hit;
    r = px[11:8];
    g = px[7:4];
    b = px[3:0];
    case (sel)
      C_SEL_RED:   hit = (r >= thr_main) && (g <= thr_other) && (b <= thr_other);
      C_SEL_GREEN: hit = (g >= thr_main) && (r <= thr_other) && (b <= thr_other);
      C_SEL_BLUE:  hit = (b >= thr_main) && (r <= thr_other) && (g <= thr_other);
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/color_obj_detect_if.sv
// Pixel stream in/out, detection controls and published frame results.
interface color_obj_detect_if;
  import color_obj_detect_pkg::*;

  logic [c_nb_img_pxls-1:0]  addr;
  logic [c_nb_buf-1:0]       din;
  logic                      we;
  logic [1:0]                color_sel;
  logic [c_nb_chan-1:0]      thr_main;
  logic [c_nb_chan-1:0]      thr_other;
  logic                      show_match;
  logic                      show_box;

  logic [c_nb_img_pxls-1:0]  addr_out;
  logic [c_nb_buf-1:0]       dout_out;
  logic                      we_out;
  logic                      frame_done;
  logic                      obj_found;
  logic [c_nb_line_pxls-1:0] xmin;
  logic [c_nb_line_pxls-1:0] xmax;
  logic [c_nb_rows-1:0]      ymin;
  logic [c_nb_rows-1:0]      ymax;
  logic [c_nb_img_pxls-1:0]  pix_cnt;

  modport slave (
    input  addr, din, we, color_sel, thr_main, thr_other, show_match, show_box,
    output addr_out, dout_out, we_out, frame_done, obj_found, xmin, xmax, ymin, ymax, pix_cnt
  );

  modport master (
    output addr, din, we, color_sel, thr_main, thr_other, show_match, show_box,
    input  addr_out, dout_out, we_out, frame_done, obj_found, xmin, xmax, ymin, ymax, pix_cnt
  );

endinterface

// File: rtl/color_obj_detect_track.sv
// Address-to-row/column tracker with frame-active state and end/wrap detection.
// Outputs are registered and aligned with the detector's first pipeline stage.
module pxl_rowcol_track
  import color_obj_detect_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [c_nb_img_pxls-1:0]  addr_i,
  output logic [c_nb_rows-1:0]      row_o,
  output logic [c_nb_line_pxls-1:0] col_o,
  output logic                      act_o,
  output logic                      last_o,
  output logic                      wrap_o
);

  trk_state_e                state_q, state_d;
  logic [c_nb_img_pxls-1:0]  line_base_q, line_base_d;
  logic [c_nb_img_pxls-1:0]  next_base_c;
  logic [c_nb_img_pxls-1:0]  prev_addr_q;
  logic [c_nb_rows-1:0]      row_q, row_d;
  logic [c_nb_line_pxls-1:0] col_q, col_d;
  logic                      act_q, last_q, wrap_q;
  logic                      act_c, last_c, wrap_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= TRK_IDLE;
    else      state_q <= state_d;
  end

  // Next state: addr 0 opens a frame; last pixel or a backwards jump closes it
  always_comb begin
    state_d = state_q;
    if (valid_i) begin
      if (addr_i == '0)          state_d = TRK_ACTIVE;
      else if (wrap_c || last_c) state_d = TRK_IDLE;
    end
  end

  // Per-write classification; a wrap to addr 0 already belongs to the new frame
  always_comb begin
    wrap_c = 1'b0;
    act_c  = 1'b0;
    last_c = 1'b0;
    if (valid_i) begin
      wrap_c = (state_q == TRK_ACTIVE) && (addr_i < prev_addr_q);
      act_c  = (addr_i == '0) || ((state_q == TRK_ACTIVE) && !wrap_c);
      last_c = act_c && (addr_i == c_last_addr);
    end
  end

  // Row/column arithmetic, advancing at most one line per write
  always_comb begin
    next_base_c = line_base_q + c_cols_addr;
    line_base_d = line_base_q;
    row_d       = row_q;
    col_d       = col_q;
    if (valid_i) begin
      if (addr_i == '0) begin
        line_base_d = '0;
        row_d       = '0;
        col_d       = '0;
      end else if (addr_i >= next_base_c) begin
        line_base_d = next_base_c;
        row_d       = row_q + c_nb_rows'(1);
        col_d       = c_nb_line_pxls'(addr_i - next_base_c);
      end else begin
        col_d       = c_nb_line_pxls'(addr_i - line_base_q);
      end
    end
  end

  // Tracker datapath and stage-aligned flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_base_q <= '0;
      prev_addr_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      act_q       <= 1'b0;
      last_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      line_base_q <= line_base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      act_q       <= act_c;
      last_q      <= last_c;
      wrap_q      <= wrap_c;
      if (valid_i) prev_addr_q <= addr_i;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign act_o  = act_q;
  assign last_o = last_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/color_obj_detect.sv
// Colour-threshold object detector: forwards the capture pixel stream two cycles
// late, optionally painted, and publishes per-frame bounding box and match count.
module color_obj_detect
  import color_obj_detect_pkg::*;
(
  input logic               clk,
  input logic               rst,
  color_obj_detect_if.slave bus
);

  logic                      valid_c, start_c, match_c;
  color_sel_e                sel_q, sel_c;
  logic [c_nb_chan-1:0]      thr_main_q, thr_main_c;
  logic [c_nb_chan-1:0]      thr_other_q, thr_other_c;

  logic [c_nb_img_pxls-1:0]  s1_addr_q;
  logic [c_nb_buf-1:0]       s1_din_q;
  logic                      s1_valid_q, s1_match_q;
  logic [c_nb_rows-1:0]      s1_row;
  logic [c_nb_line_pxls-1:0] s1_col;
  logic                      s1_act, s1_last, s1_wrap;

  bbox_t                     work_q, work_d, snap_q, snap_d, base_c, upd_c, res_q;
  logic                      hit_c, pub_q, pub_d, found_q, done_q;
  logic                      in_x_c, in_y_c, border_c;

  logic [c_nb_img_pxls-1:0]  addr_out_q;
  logic [c_nb_buf-1:0]       dout_q, dout_d;
  logic                      we_out_q;

  assign valid_c = bus.we && (bus.addr < c_pxls_addr);
  assign start_c = valid_c && (bus.addr == '0);

  // Frame-start pixel classifies with the live settings it is latching
  always_comb begin
    sel_c       = sel_q;
    thr_main_c  = thr_main_q;
    thr_other_c = thr_other_q;
    if (start_c) begin
      sel_c       = color_sel_e'(bus.color_sel);
      thr_main_c  = bus.thr_main;
      thr_other_c = bus.thr_other;
    end
    match_c = valid_c && pix_match(bus.din, sel_c, thr_main_c, thr_other_c);
  end

  // Detection settings held for the whole frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q       <= C_SEL_OFF;
      thr_main_q  <= '0;
      thr_other_q <= '0;
    end else if (start_c) begin
      sel_q       <= sel_c;
      thr_main_q  <= thr_main_c;
      thr_other_q <= thr_other_c;
    end
  end

  // Stage 1: latch the write and its match bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_addr_q  <= '0;
      s1_din_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_match_q <= 1'b0;
    end else begin
      s1_addr_q  <= bus.addr;
      s1_din_q   <= bus.din;
      s1_valid_q <= valid_c;
      s1_match_q <= match_c;
    end
  end

  pxl_rowcol_track u_track (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_c),
    .addr_i  (bus.addr),
    .row_o   (s1_row),
    .col_o   (s1_col),
    .act_o   (s1_act),
    .last_o  (s1_last),
    .wrap_o  (s1_wrap)
  );

  // Working box update; at a frame end the finished box goes to the snapshot
  always_comb begin
    hit_c  = s1_act && s1_match_q;
    base_c = s1_wrap ? c_bbox_init : work_q;
    upd_c  = base_c;
    if (hit_c) begin
      if (s1_col < base_c.xmin) upd_c.xmin = s1_col;
      if (s1_col > base_c.xmax) upd_c.xmax = s1_col;
      if (s1_row < base_c.ymin) upd_c.ymin = s1_row;
      if (s1_row > base_c.ymax) upd_c.ymax = s1_row;
      if (base_c.cnt != '1)     upd_c.cnt  = base_c.cnt + c_nb_img_pxls'(1);
    end
    work_d = upd_c;
    snap_d = snap_q;
    pub_d  = 1'b0;
    if (s1_wrap) begin
      snap_d = work_q;
      pub_d  = 1'b1;
    end else if (s1_last) begin
      snap_d = upd_c;
      work_d = c_bbox_init;
      pub_d  = 1'b1;
    end
  end

  // Paint: box border over matched colour over the original pixel
  always_comb begin
    in_x_c   = (s1_col >= res_q.xmin) && (s1_col <= res_q.xmax);
    in_y_c   = (s1_row >= res_q.ymin) && (s1_row <= res_q.ymax);
    border_c = bus.show_box && found_q && s1_act &&
               ((((s1_col == res_q.xmin) || (s1_col == res_q.xmax)) && in_y_c) ||
                (((s1_row == res_q.ymin) || (s1_row == res_q.ymax)) && in_x_c));
    dout_d   = s1_din_q;
    if (border_c)                                  dout_d = c_box_color;
    else if (bus.show_match && s1_act && s1_match_q) dout_d = c_match_color;
  end

  // Stage 2: forwarded stream and working statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_out_q <= '0;
      dout_q     <= '0;
      we_out_q   <= 1'b0;
      work_q     <= c_bbox_init;
      snap_q     <= '0;
      pub_q      <= 1'b0;
    end else begin
      addr_out_q <= s1_addr_q;
      dout_q     <= dout_d;
      we_out_q   <= s1_valid_q;
      work_q     <= work_d;
      snap_q     <= snap_d;
      pub_q      <= pub_d;
    end
  end

  // Publish finished frame results one cycle after the end write leaves stage 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= pub_q;
      if (pub_q) begin
        found_q <= (snap_q.cnt != '0);
        res_q   <= (snap_q.cnt != '0) ? snap_q : '0;
      end
    end
  end

  assign bus.addr_out   = addr_out_q;
  assign bus.dout_out   = dout_q;
  assign bus.we_out     = we_out_q;
  assign bus.frame_done = done_q;
  assign bus.obj_found  = found_q;
  assign bus.xmin       = res_q.xmin;
  assign bus.xmax       = res_q.xmax;
  assign bus.ymin       = res_q.ymin;
  assign bus.ymax       = res_q.ymax;
  assign bus.pix_cnt    = res_q.cnt;

endmodule

// File: tb/tb_color_obj_detect.sv
// Directed bench for color_obj_detect: reset, spaced and back-to-back frames,
// detection off, frame wrap and paint modes.
module tb_color_obj_detect;
  import color_obj_detect_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  color_obj_detect_if bus ();

  color_obj_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] out_mem  [0:4799];
  int          out_cnt;
  int          done_cnt;
  logic [39:0] cap_res  [0:15];

  // Output recorder: forwarded pixels by address and published results per frame
  always @(negedge clk) begin
    if (bus.we_out === 1'b1) begin
      if (bus.addr_out < 13'd4800) out_mem[bus.addr_out] <= bus.dout_out;
      out_cnt <= out_cnt + 1;
    end
    if (bus.frame_done === 1'b1) begin
      cap_res[done_cnt[3:0]] <= {bus.obj_found, bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.pix_cnt};
      done_cnt <= done_cnt + 1;
    end
  end

  // Test image: red block at cols 10..19, rows 20..29
  function automatic logic [11:0] exp_px(input int a);
    int r;
    int c;
    r = a / 80;
    c = a % 80;
    return (r >= 20 && r <= 29 && c >= 10 && c <= 19) ? 12'hF00 : 12'h000;
  endfunction

  function automatic int stream_errs();
    int n;
    n = 0;
    for (int a = 0; a < 4800; a++) if (out_mem[a] !== exp_px(a)) n++;
    return n;
  endfunction

  task automatic send_range(input int a0, input int a1, input int spacing, input bit px0_red);
    for (int a = a0; a <= a1; a++) begin
      @(negedge clk);
      bus.we   = 1'b1;
      bus.addr = 13'(a);
      bus.din  = (a == 0 && px0_red) ? 12'hF00 : exp_px(a);
      if (spacing > 1) begin
        @(negedge clk);
        bus.we = 1'b0;
        repeat (spacing - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] sel, input logic smatch, input logic sbox);
    bus.color_sel  = sel;
    bus.thr_main   = 4'd8;
    bus.thr_other  = 4'd3;
    bus.show_match = smatch;
    bus.show_box   = sbox;
  endtask

  localparam logic [39:0] RES_BOX  = {1'b1, 7'd10, 7'd19, 6'd20, 6'd29, 13'd100};
  localparam logic [39:0] RES_NONE = 40'd0;

  task automatic test_reset();
    rst = 1'b0;
    bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    set_cfg(2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.we = 1'b1; bus.addr = 13'd100; bus.din = 12'hFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.we_out !== 1'b0) begin errors++; $display("FAIL reset_we_out got %b want 0", bus.we_out); end
    checks++;
    if (bus.dout_out !== 12'h000 || bus.addr_out !== 13'd0) begin
      errors++; $display("FAIL reset_stream got addr %0d dout %h want 0 0", bus.addr_out, bus.dout_out);
    end
    checks++;
    if ({bus.frame_done, bus.obj_found, bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.pix_cnt} !== 41'd0) begin
      errors++; $display("FAIL reset_results got %b%b %0d %0d %0d %0d %0d want all 0", bus.frame_done,
                         bus.obj_found, bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.pix_cnt);
    end
    bus.we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 13'd5; bus.din = 12'hABC;
    @(negedge clk);
    bus.we = 1'b0;
    checks++;
    if (bus.we_out !== 1'b0) begin errors++; $display("FAIL first_write_early got we_out %b want 0", bus.we_out); end
    @(negedge clk);
    checks++;
    if (bus.we_out !== 1'b1 || bus.addr_out !== 13'd5 || bus.dout_out !== 12'hABC) begin
      errors++; $display("FAIL first_write_fwd got we %b addr %0d dout %h want 1 5 abc",
                         bus.we_out, bus.addr_out, bus.dout_out);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || bus.pix_cnt !== 13'd0) begin
      errors++; $display("FAIL prestart_ignored got done %0d cnt %0d want 0 0", done_cnt, bus.pix_cnt);
    end
  endtask

  task automatic test_bbox_spaced();
    int d0;
    int n;
    d0 = done_cnt;
    set_cfg(2'd0, 1'b0, 1'b0);
    send_range(0, 4799, 8, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL spaced_done_count got %0d want %0d", done_cnt - d0, 1); end
    checks++;
    if (cap_res[d0] !== RES_BOX) begin errors++; $display("FAIL spaced_results got %h want %h", cap_res[d0], RES_BOX); end
    checks++;
    if ({bus.obj_found, bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.pix_cnt} !== RES_BOX) begin
      errors++; $display("FAIL spaced_held got %h want %h",
                         {bus.obj_found, bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.pix_cnt}, RES_BOX);
    end
    n = stream_errs();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL spaced_stream got %0d bad pixels want 0", n); end
  endtask

  task automatic test_paint();
    set_cfg(2'd0, 1'b0, 1'b1);
    send_range(0, 4799, 1, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (out_mem[20*80+10] !== 12'hF0F) begin errors++; $display("FAIL box_corner got %h want f0f", out_mem[20*80+10]); end
    checks++;
    if (out_mem[25*80+19] !== 12'hF0F) begin errors++; $display("FAIL box_right got %h want f0f", out_mem[25*80+19]); end
    checks++;
    if (out_mem[20*80+15] !== 12'hF0F) begin errors++; $display("FAIL box_top got %h want f0f", out_mem[20*80+15]); end
    checks++;
    if (out_mem[25*80+15] !== 12'hF00) begin errors++; $display("FAIL box_interior got %h want f00", out_mem[25*80+15]); end
    checks++;
    if (out_mem[20*80+9] !== 12'h000) begin errors++; $display("FAIL box_outside got %h want 000", out_mem[20*80+9]); end
    set_cfg(2'd0, 1'b1, 1'b1);
    send_range(0, 4799, 1, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (out_mem[25*80+15] !== 12'hFFF) begin errors++; $display("FAIL match_interior got %h want fff", out_mem[25*80+15]); end
    checks++;
    if (out_mem[20*80+10] !== 12'hF0F) begin errors++; $display("FAIL match_box_prio got %h want f0f", out_mem[20*80+10]); end
    checks++;
    if (out_mem[20*80+20] !== 12'h000) begin errors++; $display("FAIL match_bg got %h want 000", out_mem[20*80+20]); end
  endtask

  task automatic test_sel_off();
    int d0;
    int n;
    d0 = done_cnt;
    set_cfg(2'd3, 1'b0, 1'b0);
    send_range(0, 4799, 2, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL off_done_count got %0d want 1", done_cnt - d0); end
    checks++;
    if (cap_res[d0] !== RES_NONE) begin errors++; $display("FAIL off_results got %h want %h", cap_res[d0], RES_NONE); end
    n = stream_errs();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL off_stream got %0d bad pixels want 0", n); end
  endtask

  task automatic test_wrap();
    int d0;
    logic [39:0] exp2;
    d0 = done_cnt;
    exp2 = {1'b1, 7'd0, 7'd19, 6'd0, 6'd29, 13'd101};
    set_cfg(2'd0, 1'b0, 1'b0);
    send_range(0, 4000, 1, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL wrap_no_early_end got %0d want 0", done_cnt - d0); end
    send_range(0, 4799, 1, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 2) begin errors++; $display("FAIL wrap_done_count got %0d want 2", done_cnt - d0); end
    checks++;
    if (cap_res[d0] !== RES_BOX) begin errors++; $display("FAIL wrap_first got %h want %h", cap_res[d0], RES_BOX); end
    checks++;
    if (cap_res[d0+1] !== exp2) begin errors++; $display("FAIL wrap_second got %h want %h", cap_res[d0+1], exp2); end
  endtask

  task automatic test_back_to_back();
    int d0;
    int c0;
    int n;
    d0 = done_cnt;
    c0 = out_cnt;
    set_cfg(2'd0, 1'b0, 1'b0);
    send_range(0, 4799, 1, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
    checks++;
    if (cap_res[d0] !== RES_BOX) begin errors++; $display("FAIL b2b_results got %h want %h", cap_res[d0], RES_BOX); end
    checks++;
    if (out_cnt - c0 !== 4800) begin errors++; $display("FAIL b2b_out_count got %0d want 4800", out_cnt - c0); end
    n = stream_errs();
    checks++;
    if (n !== 0) begin errors++; $display("FAIL b2b_stream got %0d bad pixels want 0", n); end
    c0 = out_cnt;
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 13'd4800; bus.din = 12'h123;
    @(negedge clk);
    bus.we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.we_out !== 1'b0 || bus.addr_out !== 13'd4800) begin
      errors++; $display("FAIL oob_write got we %b addr %0d want 0 4800", bus.we_out, bus.addr_out);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (out_cnt !== c0 || done_cnt !== d0 + 1) begin
      errors++; $display("FAIL oob_side_effect got outs %0d done %0d want 0 1", out_cnt - c0, done_cnt - d0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    out_cnt  = 0;
    done_cnt = 0;
    test_reset();
    test_bbox_spaced();
    test_paint();
    test_sel_off();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
